// File: rtl/shift_sll_seq.sv
// -----------------------------------------------------------------------------
// shift_sll_seq
//
// Multi-cycle logical left shifter (SLL) for the execute stage. The left-
// direction counterpart of the combinational arithmetic right shifter
// (shift_sra). It shifts at most STEP bit positions per clock, so a large
// shift amount costs more cycles but needs only a small shifter.
//
// Handshake: a request on 'start' is accepted whenever the unit is not busy
// (IDLE or DONE). 'busy' is high while shifting. 'done' pulses for exactly one
// cycle when 'result' is valid. 'result' then holds until the next accepted
// start. A start seen while busy is dropped, not queued.
//
// Optional feature macro: SHIFT_WORD_EN
//   Defined   : word=1 selects RV64 SLLW/SLLIW behaviour. Only the low half
//               of 'a' is shifted, the shift amount drops its MSB, and the
//               final value is the sign extension of bit HALF-1.
//   Undefined : 'word' is ignored. Every operation is a full-width SLL.
//
// Parameters
//   WIDTH    operand/result width (64)
//   SHAMT_W  shift-amount width, log2(WIDTH) (6)
//   STEP     max bits shifted per cycle, power of two in 1..WIDTH/2 (4)
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   start   in   request, sampled only when busy==0
//   a       in   [WIDTH-1:0]   operand, captured on the accepted start edge
//   n       in   [SHAMT_W-1:0] shift amount, captured on the accepted start
//   word    in   word-op select (only with SHIFT_WORD_EN)
//   busy    out  shifting in progress
//   done    out  one-cycle pulse, result valid
//   result  out  [WIDTH-1:0]   shifted value
// -----------------------------------------------------------------------------
module shift_sll_seq #(
   parameter int WIDTH   = 64,
   parameter int SHAMT_W = 6,
   parameter int STEP    = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [SHAMT_W-1:0] n,
   input  logic               word,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result
);

   localparam int HALF = WIDTH / 2;

   // STEP is at most WIDTH/2, so it always fits in the shift-amount width.
   localparam logic [SHAMT_W-1:0] STEP_V = SHAMT_W'(STEP);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             state;
   state_t             next_state;
   logic [WIDTH-1:0]   work;        // working register, drives result
   logic [SHAMT_W-1:0] remaining;   // positions still to shift

   logic               accept;      // start taken at this edge
   logic [SHAMT_W-1:0] n_eff;       // shift amount after word masking
   logic [WIDTH-1:0]   load_value;  // value loaded into work on accept
   logic               last_step;   // this SHIFT edge finishes the operation
   logic [SHAMT_W-1:0] k;           // positions shifted this edge
   logic [WIDTH-1:0]   shifted;     // work << k, zero filled
   logic [WIDTH-1:0]   shift_value; // value written to work on a SHIFT edge

   // Sign-extend the low half of a value into the full width.
   function automatic logic [WIDTH-1:0] sext_half(input logic [WIDTH-1:0] v);
      return {{HALF{v[HALF-1]}}, v[HALF-1:0]};
   endfunction

   // ---------------------------------------------------------------------------
   // Handshake and per-edge shift datapath
   // ---------------------------------------------------------------------------
   assign accept    = start && (state != S_SHIFT);
   assign last_step = (remaining <= STEP_V);
   assign k         = last_step ? remaining : STEP_V;
   assign shifted   = work << k;

`ifdef SHIFT_WORD_EN
   logic word_q;   // word mode of the operation in flight

   // NOTE: every signal assigned in an always_comb gets a default first, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      n_eff      = n;
      load_value = a;
      if (word) begin
         n_eff = {1'b0, n[SHAMT_W-2:0]};
         // A zero-length word shift still has to return the sign-extended
         // low half, since it goes straight to DONE without a final shift.
         if (n_eff == '0) begin
            load_value = sext_half(a);
         end else begin
            load_value = {{HALF{1'b0}}, a[HALF-1:0]};
         end
      end
   end

   always_comb begin
      shift_value = shifted;
      // Upper bits are garbage until the final edge, where bit HALF-1 of the
      // fully shifted low half is replicated upward.
      if (word_q && last_step) begin
         shift_value = sext_half(shifted);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q <= 1'b0;
      end else if (accept) begin
         word_q <= word;
      end
   end
`else
   // 'word' has no effect in this build; it is tied off here so it can never
   // steer the datapath or carry an X into it.
   logic unused_word;
   assign unused_word = word;

   always_comb begin
      n_eff       = n;
      load_value  = a;
      shift_value = shifted;
   end
`endif

   // ---------------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------------
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE, S_DONE: begin
            // DONE falls through to a new request directly, so back-to-back
            // operations have no dead cycle.
            if (start) begin
               next_state = (n_eff == '0) ? S_DONE : S_SHIFT;
            end else begin
               next_state = S_IDLE;
            end
         end
         S_SHIFT: begin
            next_state = last_step ? S_DONE : S_SHIFT;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   // NOTE: work and remaining are plain registers rather than a memory; they
   // are reset so the result port reads zero after reset and an aborted
   // operation leaves nothing behind.
   always_ff @(posedge clk) begin
      if (rst) begin
         work      <= '0;
         remaining <= '0;
      end else if (accept) begin
         work      <= load_value;
         remaining <= n_eff;
      end else if (state == S_SHIFT) begin
         work      <= shift_value;
         remaining <= remaining - k;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign busy   = (state == S_SHIFT);
   assign done   = (state == S_DONE);
   assign result = work;

endmodule

// File: tb/tb_shift_sll_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_sll_seq
//
// Directed bench for shift_sll_seq (WIDTH=64, SHAMT_W=6, STEP=4). A table of
// single operations is applied in a loop, each checked for latency, busy
// length, result, single done pulse and result hold. Hand-written sequences
// then cover reset, start-while-busy, abort by reset and back-to-back starts.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_shift_sll_seq;

   localparam int WIDTH   = 64;
   localparam int SHAMT_W = 6;
   localparam int STEP    = 4;
   localparam int TIMEOUT = 80;

   logic               clk;
   logic               rst;
   logic               start;
   logic [WIDTH-1:0]   a_in;
   logic [SHAMT_W-1:0] n_in;
   logic               word_in;
   logic               busy;
   logic               done;
   logic [WIDTH-1:0]   result;

   int total_cnt  = 0;
   int passed_cnt = 0;
   int edge_cnt   = 0;

   shift_sll_seq #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W),
      .STEP    (STEP)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a_in),
      .n      (n_in),
      .word   (word_in),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string              name;
      logic [WIDTH-1:0]   a;
      logic [SHAMT_W-1:0] n;
      logic               word;
      logic [WIDTH-1:0]   exp_res;
      int                 exp_lat;
   } vec_t;

   task automatic check(input string name, input logic [WIDTH-1:0] act,
                        input logic [WIDTH-1:0] exp);
      total_cnt++;
      if (act === exp) begin
         passed_cnt++;
      end else begin
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One rising edge, then settle on the falling edge for sampling/driving.
   task automatic step();
      @(posedge clk);
      edge_cnt++;
      @(negedge clk);
   endtask

   // Issue one operation and follow it to done and one cycle beyond.
   task automatic run_op(input vec_t v);
      int busy_cnt;
      a_in     = v.a;
      n_in     = v.n;
      word_in  = v.word;
      start    = 1'b1;
      edge_cnt = 0;
      busy_cnt = 0;
      step();
      start = 1'b0;
      while (!done && edge_cnt < TIMEOUT) begin
         if (busy) busy_cnt++;
         step();
      end
      check({v.name, " done seen"}, 64'(done), 64'd1);
      check({v.name, " latency"}, 64'(edge_cnt), 64'(v.exp_lat));
      check({v.name, " busy cycles"}, 64'(busy_cnt), 64'(v.exp_lat - 1));
      check({v.name, " busy low at done"}, 64'(busy), 64'd0);
      check({v.name, " result"}, result, v.exp_res);
      step();
      check({v.name, " done single pulse"}, 64'(done), 64'd0);
      check({v.name, " result held"}, result, v.exp_res);
   endtask

   vec_t vecs[$];
   int   done_cnt;
   int   first_edge;

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      a_in    = '0;
      n_in    = '0;
      word_in = 1'b0;

      vecs.push_back('{"n63", 64'h0000_0000_0000_0001, 6'd63, 1'b0,
                       64'h8000_0000_0000_0000, 17});
      vecs.push_back('{"n6", 64'hCAAA_AAAA_AAAA_AAAA, 6'd6, 1'b0,
                       64'hAAAA_AAAA_AAAA_AA80, 3});
      vecs.push_back('{"n0", 64'hCAAA_AAAA_AAAA_AAAA, 6'd0, 1'b0,
                       64'hCAAA_AAAA_AAAA_AAAA, 1});
      vecs.push_back('{"n2", 64'd3, 6'd2, 1'b0, 64'd12, 2});
      vecs.push_back('{"n3_short", 64'd1, 6'd3, 1'b0, 64'd8, 2});
      vecs.push_back('{"n4_exact", 64'hFFFF_FFFF_FFFF_FFFF, 6'd4, 1'b0,
                       64'hFFFF_FFFF_FFFF_FFF0, 2});
      vecs.push_back('{"n5", 64'd1, 6'd5, 1'b0, 64'd32, 3});
      vecs.push_back('{"n8", 64'h0123_4567_89AB_CDEF, 6'd8, 1'b0,
                       64'h2345_6789_ABCD_EF00, 3});
      vecs.push_back('{"top_drop", 64'h8000_0000_0000_0001, 6'd1, 1'b0,
                       64'h0000_0000_0000_0002, 2});
      vecs.push_back('{"word_small", 64'h0000_0000_0000_00FF, 6'd4, 1'b1,
                       64'h0000_0000_0000_0FF0, 2});
`ifdef SHIFT_WORD_EN
      vecs.push_back('{"word_n33", 64'h0000_0000_4000_0001, 6'd33, 1'b1,
                       64'hFFFF_FFFF_8000_0002, 2});
`else
      vecs.push_back('{"word_n33", 64'h0000_0000_4000_0001, 6'd33, 1'b1,
                       64'h8000_0002_0000_0000, 10});
`endif

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset result", result, 64'd0);
      rst = 1'b0;
      step();
      check("idle after reset", 64'(busy | done), 64'd0);

      // Table-driven single operations.
      foreach (vecs[i]) begin
         run_op(vecs[i]);
      end

      // Start while busy is ignored: a=1, n=40 runs to 1<<40 at edge 11.
      word_in  = 1'b0;
      a_in     = 64'd1;
      n_in     = 6'd40;
      start    = 1'b1;
      edge_cnt = 0;
      step();
      start = 1'b0;
      step();
      step();
      a_in  = 64'hFFFF_FFFF_FFFF_FFFF;
      n_in  = 6'd1;
      start = 1'b1;
      step();
      start      = 1'b0;
      done_cnt   = 0;
      first_edge = 0;
      for (int c = 0; c < 30; c++) begin
         if (done) begin
            done_cnt++;
            if (first_edge == 0) first_edge = edge_cnt;
            if (done_cnt == 1) check("ignore result", result, 64'h0000_0100_0000_0000);
         end
         step();
      end
      check("ignore done count", 64'(done_cnt), 64'd1);
      check("ignore latency", 64'(first_edge), 64'd11);
      check("ignore result held", result, 64'h0000_0100_0000_0000);

      // Abort by reset at the 5th edge of a long operation.
      a_in     = 64'd1;
      n_in     = 6'd60;
      start    = 1'b1;
      edge_cnt = 0;
      step();
      start = 1'b0;
      step();
      step();
      step();
      check("abort busy before rst", 64'(busy), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort busy", 64'(busy), 64'd0);
      check("abort done", 64'(done), 64'd0);
      check("abort result", result, 64'd0);
      done_cnt = 0;
      for (int c = 0; c < 25; c++) begin
         if (done) done_cnt++;
         step();
      end
      check("abort no done", 64'(done_cnt), 64'd0);
      run_op('{"after_abort", 64'd3, 6'd2, 1'b0, 64'd12, 2});

      // Back-to-back: restart in the done cycle of a=1, n=4.
      a_in     = 64'd1;
      n_in     = 6'd4;
      start    = 1'b1;
      edge_cnt = 0;
      step();
      start = 1'b0;
      check("b2b first busy", 64'(busy), 64'd1);
      step();
      check("b2b first done", 64'(done), 64'd1);
      check("b2b first result", result, 64'd16);
      a_in  = 64'd5;
      n_in  = 6'd8;
      start = 1'b1;
      step();
      start = 1'b0;
      check("b2b no idle gap", 64'(busy), 64'd1);
      check("b2b no extra done", 64'(done), 64'd0);
      step();
      check("b2b second busy", 64'(busy), 64'd1);
      step();
      check("b2b second done", 64'(done), 64'd1);
      check("b2b second result", result, 64'h500);
      step();
      check("b2b idle after", 64'(busy | done), 64'd0);

      $display("%0d/%0d checks passed", passed_cnt, total_cnt);
      $finish;
   end

endmodule
